// File: rtl/memory_pkg.sv
// Shared definitions for the 16-bit memory port: geometry defaults, FSM encoding,
// access-counter width and a small counter helper.
package memory_pkg;

    localparam int MEM_ADDR_WIDTH = 12;
    localparam int MEM_WIDE       = 16;
    localparam int CNT_WIDTH      = 16;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    // Counters wrap silently from all-ones back to zero.
    function automatic cnt_t cnt_inc(input cnt_t cnt, input logic en);
        return cnt + cnt_t'(en);
    endfunction

endpackage : memory_pkg

// File: rtl/memory_responder_if.sv
// Memory port between the processor-side initiator (master) and the responder (slave).
interface memory_responder_if
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int WIDE       = MEM_WIDE
) ();

    logic                  mem_enable;
    logic                  read_enable;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] address;
    logic [WIDE-1:0]       data_in;
    logic [WIDE-1:0]       data_out;
    logic                  init_done;
    cnt_t                  read_count;
    cnt_t                  write_count;

    modport master (
        output mem_enable,
        output read_enable,
        output write_enable,
        output address,
        output data_in,
        input  data_out,
        input  init_done,
        input  read_count,
        input  write_count
    );

    modport slave (
        input  mem_enable,
        input  read_enable,
        input  write_enable,
        input  address,
        input  data_in,
        output data_out,
        output init_done,
        output read_count,
        output write_count
    );

endinterface : memory_responder_if

// File: rtl/memory_responder_array.sv
// Single-port synchronous RAM with registered, read-before-write output.
// The output register clears on srst so a dropped read leaves zero on the port.
module memory_array_16 #(
    parameter int ADDR_WIDTH = 12,
    parameter int WIDE       = 16
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDE-1:0]       wdata,
    output logic [WIDE-1:0]       rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDE-1:0] mem_q [DEPTH];
    logic [WIDE-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Same-edge read sees the pre-write contents because both use the old array value.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_q <= '0;
        end else if (re) begin
            rd_data_q <= mem_q[addr];
        end
    end

    assign rdata = rd_data_q;

endmodule : memory_array_16

// File: rtl/memory_responder.sv
// Memory-side responder: zeroing sweep after reset, then line reads/writes with
// one cycle of read latency and wrap-around access counters.
module memory_responder
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH     = MEM_ADDR_WIDTH,
    parameter int WIDE           = MEM_WIDE,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    memory_responder_if.slave bus
);

    localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_ptr_q, clear_ptr_d;
    logic                  init_done_q, init_done_d;
    cnt_t                  read_count_q, read_count_d;
    cnt_t                  write_count_q, write_count_d;

    logic                  sweep_last;
    logic                  acc;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [WIDE-1:0]       ram_wdata;
    logic [WIDE-1:0]       ram_rdata;

    assign sweep_last = (clear_ptr_q == {ADDR_WIDTH{1'b1}});

    // Reset in the same cycle as a request drops it entirely.
    assign acc = bus.mem_enable & init_done_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                if (sweep_last) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = RESET_STATE;
        endcase
    end

    // RAM port mux: sweep address and zero data while clearing, the bus otherwise.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = bus.address;
        ram_wdata = bus.data_in;
        rd_acc    = 1'b0;
        wr_acc    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                ram_we    = ~reset;
                ram_addr  = clear_ptr_q;
                ram_wdata = '0;
            end
            ST_READY: begin
                rd_acc = acc & bus.read_enable;
                wr_acc = acc & bus.write_enable;
                ram_we = wr_acc;
                ram_re = rd_acc;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    always_comb begin
        clear_ptr_d   = clear_ptr_q;
        if (state_q == ST_CLEAR) begin
            clear_ptr_d = clear_ptr_q + ADDR_WIDTH'(1);
        end
        read_count_d  = cnt_inc(read_count_q, rd_acc);
        write_count_d = cnt_inc(write_count_q, wr_acc);
        // Rises on the same edge that commits the last sweep write.
        init_done_d   = (state_d == ST_READY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clear_ptr_q   <= '0;
            init_done_q   <= 1'b0;
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            clear_ptr_q   <= clear_ptr_d;
            init_done_q   <= init_done_d;
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    memory_array_16 #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDE       (WIDE)
    ) u_array (
        .clk   (clk),
        .srst  (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.data_out    = ram_rdata;
    assign bus.init_done   = init_done_q;
    assign bus.read_count  = read_count_q;
    assign bus.write_count = write_count_q;

endmodule : memory_responder
